rom_fetch_unit: RTL and testbench
=================================

// Module: rom_fetch_unit
// PURPOSE
//  Bus initiator for the instruction ROM: drives ROM_ADDR, captures ROM_DATA after the ROM's
//  fixed read latency, buffers fetched bytes in a small prefetch FIFO and hands them to the
//  processor core over a VALID/READY interface. Supports branch redirect (flush + refetch).
//  Sits between the ROM and the core's decode stage.
// PARAMETERS
//  ADDR_WIDTH   8     ROM address width; address arithmetic wraps modulo 2**ADDR_WIDTH
//  DATA_WIDTH   8     ROM data / instruction byte width
//  FIFO_DEPTH   4     prefetch entries (power of 2, >= ROM_LATENCY+2)
//  ROM_LATENCY  1     cycles from ROM_ADDR presented to ROM_DATA valid (ROM registers ADDR)
//  START_ADDR   8'h00 first fetch address after reset
// PORTS
//  CLK          in   1   clock, all state on rising edge
//  RESET        in   1   synchronous, active-low reset
//  ENABLE       in   1   1 = issue new ROM reads; 0 = stop issuing (in-flight reads complete)
//  ROM_ADDR     out  AW  registered address presented to ROM
//  ROM_DATA     in   DW  ROM read data
//  BRANCH_EN    in   1   redirect request, single-cycle pulse
//  BRANCH_ADDR  in   AW  redirect target
//  INSTR_DATA   out  DW  FIFO head data
//  INSTR_ADDR   out  AW  ROM address the head byte was fetched from
//  INSTR_VALID  out  1   FIFO head valid
//  INSTR_READY  in   1   core accepts head this cycle when INSTR_VALID=1
// BEHAVIOUR
//  Reset (RESET=0 at edge): ROM_ADDR=START_ADDR, INSTR_VALID=0, INSTR_DATA=0, INSTR_ADDR=0,
//   FIFO count=0, all in-flight tags cleared, state=IDLE. Reset overrides every other input.
//  Issue: a read is issued in cycle t when state=FETCH; address = ROM_ADDR during t; ROM_ADDR
//   increments (wraps FF->00) at end of t. In-flight tag {valid,addr} shifts ROM_LATENCY stages.
//  Capture: ROM_DATA sampled at end of cycle t+ROM_LATENCY, written to FIFO with its address;
//   INSTR_VALID=1 from cycle t+ROM_LATENCY+1 (FIFO is show-ahead). Issue->valid = 2 cycles.
//  Credit: issue only if fifo_count + inflight < FIFO_DEPTH (pop in same cycle not credited);
//   FIFO can never overflow; no fetched byte is ever dropped except by flush/reset.
//  Pop: INSTR_VALID & INSTR_READY at edge removes head; simultaneous push+pop keeps count.
//  Steady state with INSTR_READY=1: one instruction per cycle, in ascending address order.
//  FSM (registered):
//   IDLE : no issue. -> FETCH when ENABLE=1.
//   FETCH: issue each cycle. -> STALL when credit exhausted; -> IDLE when ENABLE=0.
//   STALL: no issue, ROM_ADDR held. -> FETCH when credit frees and ENABLE=1; -> IDLE if ENABLE=0.
//  Branch (BRANCH_EN=1 in cycle t): end of t FIFO cleared, all in-flight tags invalidated,
//   ROM_ADDR<=BRANCH_ADDR, state<=FETCH if ENABLE else IDLE. INSTR_VALID=0 in t+1; first
//   target byte valid in t+2+ROM_LATENCY... i.e. issue in t+1, valid in t+1+ROM_LATENCY+1.
//   Branch beats a same-cycle pop (pop ignored) and a same-cycle capture (data discarded).
//  ENABLE=0 mid-run: no new issue next cycle; in-flight reads still land in FIFO; FIFO drains.
//  INSTR_DATA/INSTR_ADDR are don't-care-stable: hold last head value when INSTR_VALID=0.
// STRUCTURE
//  fetch_pkg: FSM state enum (IDLE/FETCH/STALL), ADDR_WIDTH/DATA_WIDTH defaults, tag struct
//   {valid, addr}. Sub-module fetch_fifo (sync FIFO, show-ahead, synchronous clear, count out,
//   width AW+DW). Top holds FSM, address counter, latency tag shift register, credit logic.
// TESTING (bench uses ROM model with ROM_LATENCY=1, content = ~addr)
//  1 Reset, ENABLE=1, READY=1 -> INSTR_VALID from cycle 2, INSTR_ADDR 00,01,02.. 1/cycle, DATA=~ADDR
//  2 READY=0 from start -> count reaches 4, ROM_ADDR holds 04, state STALL; READY=1 -> 00..03 then 04
//  3 FIFO holds 3 + 1 in flight, BRANCH_EN to 80 -> VALID=0 next cycle, next delivered ADDR=80,
//    no stale byte ever delivered
//  4 Branch to FE, READY=1 -> delivered ADDR FE,FF,00,01 (wrap)
//  5 RESET=0 with FIFO full -> next cycle VALID=0, ROM_ADDR=START_ADDR, count=0, IDLE
//  6 ENABLE 1->0 mid-run -> no new ROM_ADDR change after 1 cycle, in-flight byte delivered, then VALID=0

Source files
------------

// File: rtl/rom_fetch_unit_pkg.sv
// Shared types, defaults and credit helper for the ROM instruction fetch unit.
package rom_fetch_unit_pkg;

  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ROM_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_t;

  // A read may be issued only while buffered plus outstanding bytes leave room.
  function automatic logic credit_ok(input int unsigned used, input int unsigned depth);
    return used < depth;
  endfunction

endpackage

// File: rtl/rom_fetch_unit_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear and occupancy count.
// Push when full and pop when empty are ignored; clear dominates push and pop.
module rom_fetch_unit_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop  && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !clr && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// ROM bus initiator: issues reads, tags them through the ROM latency, buffers bytes
// in a prefetch FIFO and presents them to the core over valid/ready with branch flush.
module rom_fetch_unit
  import rom_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int                    ROM_LATENCY = DEF_ROM_LATENCY,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
  } tag_t;

  fetch_state_t                   state_q;
  tag_t                           tag_q [ROM_LATENCY];
  logic [CW-1:0]                  fifo_count;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0]          hold_data;
  logic [ADDR_WIDTH-1:0]          hold_addr;
  int unsigned                    inflight;
  int unsigned                    used;
  int unsigned                    used_next;
  logic                           issue;
  logic                           push;
  logic                           pop;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight += 32'(tag_q[i].valid);
  end

  assign used        = 32'(fifo_count) + inflight;
  assign instr_valid = (fifo_count != '0);
  assign issue       = (state_q == ST_FETCH) && credit_ok(used, FIFO_DEPTH) && !branch_en;
  assign pop         = instr_valid && instr_ready && !branch_en;
  assign push        = tag_q[ROM_LATENCY-1].valid && !branch_en;
  // Occupancy seen by next cycle's issue decision; a pop this cycle frees a slot for it.
  assign used_next   = used + 32'(issue) - 32'(pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rom_addr <= START_ADDR;
    end else if (branch_en) begin
      rom_addr <= branch_addr;
      state_q  <= enable ? ST_FETCH : ST_IDLE;
    end else begin
      if (issue) rom_addr <= rom_addr + 1'b1;
      if (!enable)
        state_q <= ST_IDLE;
      else if (credit_ok(used_next, FIFO_DEPTH))
        state_q <= ST_FETCH;
      else
        state_q <= ST_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || branch_en) begin
      for (int i = 0; i < ROM_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: issue, addr: rom_addr};
      for (int i = 1; i < ROM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  rom_fetch_unit_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (branch_en),
    .push  (push),
    .din   ({tag_q[ROM_LATENCY-1].addr, rom_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Keep the last presented head visible while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_data <= '0;
      hold_addr <= '0;
    end else if (instr_valid) begin
      {hold_addr, hold_data} <= fifo_dout;
    end
  end

  assign {instr_addr, instr_data} = instr_valid ? fifo_dout : {hold_addr, hold_data};

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Scoreboard bench for rom_fetch_unit with a 1-cycle registered ROM holding ~addr.
module tb_rom_fetch_unit;
  import rom_fetch_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic       branch_en = 1'b0;
  logic [7:0] branch_addr = 8'h00;
  logic [7:0] instr_data;
  logic [7:0] instr_addr;
  logic       instr_valid;
  logic       instr_ready = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_a;

  rom_fetch_unit #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .ROM_LATENCY(1),
    .START_ADDR (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .branch_en  (branch_en),
    .branch_addr(branch_addr),
    .instr_data (instr_data),
    .instr_addr (instr_addr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= ~rom_addr;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted head must be the next expected address with data ~addr.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready && !branch_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_delivery actual addr=%h data=%h required=none", instr_addr, instr_data);
      end else begin
        exp_a = exp_q.pop_front();
        if (instr_addr !== exp_a || instr_data !== ~exp_a) begin
          errors++;
          $display("FAIL delivery actual addr=%h data=%h required addr=%h data=%h",
                   instr_addr, instr_data, exp_a, ~exp_a);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [7:0] first, input int n);
    logic [7:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 8'h01;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    instr_ready = 1'b0;
    branch_en = 1'b0;
    exp_q.delete();
    step();
    step();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    instr_ready = 1'b0;
  endtask

  task automatic pulse_branch(input logic [7:0] target);
    branch_addr = target;
    branch_en = 1'b1;
    step();
    branch_en = 1'b0;
  endtask

  initial begin
    int n;
    int bubbles;

    // 1: reset state, issue-to-valid latency, streaming 1/cycle in order
    do_reset();
    check("reset_rom_addr", 32'(rom_addr), 32'h00);
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_instr_data", 32'(instr_data), 32'h00);
    check("reset_instr_addr", 32'(instr_addr), 32'h00);
    check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    push_range(8'h00, 8);
    reset = 1'b1;
    enable = 1'b1;
    instr_ready = 1'b1;
    n = 0;
    while (rom_addr == 8'h00 && n < 10) begin
      step();
      n++;
    end
    check("t1_first_issue_seen", 32'(rom_addr), 32'h01);
    check("t1_valid_low_after_issue", 32'(instr_valid), 32'd0);
    step();
    check("t1_valid_two_after_issue", 32'(instr_valid), 32'd1);
    bubbles = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (!instr_valid) bubbles++;
    end
    check("t1_stream_bubbles", 32'(bubbles), 32'd0);
    wait_drain("t1");

    // 2: no ready from start -> fills to credit limit and stalls
    do_reset();
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t2_rom_addr_held", 32'(rom_addr), 32'h04);
    check("t2_fifo_count", 32'(dut.fifo_count), 32'd4);
    check("t2_state_stall", 32'(dut.state_q), 32'(ST_STALL));
    check("t2_head_addr", 32'(instr_addr), 32'h00);
    check("t2_head_data", 32'(instr_data), 32'hFF);
    push_range(8'h00, 8);
    instr_ready = 1'b1;
    wait_drain("t2");

    // 3: branch with 3 buffered and 1 in flight
    do_reset();
    reset = 1'b1;
    enable = 1'b1;
    n = 0;
    while (dut.fifo_count != 3'd3 && n < 20) begin
      step();
      n++;
    end
    check("t3_count_before_branch", 32'(dut.fifo_count), 32'd3);
    pulse_branch(8'h80);
    check("t3_valid_after_branch", 32'(instr_valid), 32'd0);
    check("t3_rom_addr_target", 32'(rom_addr), 32'h80);
    push_range(8'h80, 4);
    instr_ready = 1'b1;
    step();
    check("t3_valid_still_low", 32'(instr_valid), 32'd0);
    step();
    check("t3_target_valid", 32'(instr_valid), 32'd1);
    wait_drain("t3");

    // 4: branch near top of address space, wrap FF->00
    for (int i = 0; i < 4; i++) step();
    pulse_branch(8'hFE);
    push_range(8'hFE, 4);
    instr_ready = 1'b1;
    wait_drain("t4");

    // 5: reset while FIFO full
    for (int i = 0; i < 8; i++) step();
    check("t5_full_count", 32'(dut.fifo_count), 32'd4);
    reset = 1'b0;
    step();
    check("t5_valid_low", 32'(instr_valid), 32'd0);
    check("t5_rom_addr_start", 32'(rom_addr), 32'h00);
    check("t5_count_zero", 32'(dut.fifo_count), 32'd0);
    check("t5_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("t5_instr_addr_zero", 32'(instr_addr), 32'h00);

    // 6: enable drops while streaming; in-flight byte still delivered
    do_reset();
    push_range(8'h00, 6);
    reset = 1'b1;
    enable = 1'b1;
    instr_ready = 1'b1;
    n = 0;
    while (rom_addr != 8'h05 && n < 20) begin
      step();
      n++;
    end
    enable = 1'b0;
    step();
    check("t6_rom_addr_after_disable", 32'(rom_addr), 32'h06);
    wait_drain("t6");
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("t6_rom_addr_frozen", 32'(rom_addr), 32'h06);
    check("t6_valid_drained", 32'(instr_valid), 32'd0);
    check("t6_hold_addr", 32'(instr_addr), 32'h05);
    check("t6_hold_data", 32'(instr_data), 32'hFA);
    instr_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
